// File: rtl/vid_timing_pkg.sv
// ---------------------------------------------------------------------------
// vid_timing_pkg
// Shared definitions for the video timing generator:
//   - 720p60 timing constants (defaults for video_timing_gen)
//   - span_total(): derives H_TOTAL / V_TOTAL from active + porches + sync
//   - counter and pixel widths, 24-bit RGB field offsets
//   - timing_flags_t: per-pixel timing flags carried down the latency pipe
// ---------------------------------------------------------------------------
package vid_timing_pkg;

    localparam int H_ACTIVE_720P = 1280;
    localparam int H_FP_720P     = 110;
    localparam int H_SYNC_720P   = 40;
    localparam int H_BP_720P     = 220;
    localparam int V_ACTIVE_720P = 720;
    localparam int V_FP_720P     = 5;
    localparam int V_SYNC_720P   = 5;
    localparam int V_BP_720P     = 20;

    localparam int X_W   = 11;
    localparam int Y_W   = 10;
    localparam int PIX_W = 24;
    localparam int CH_W  = 8;

    // {red, green, blue} packing of the pixel source word
    localparam int RED_LSB   = 16;
    localparam int GREEN_LSB = 8;
    localparam int BLUE_LSB  = 0;

    // Flags are stored "asserted = 1"; polarity is applied only at the pins.
    typedef struct packed {
        logic act;  // active video
        logic hs;   // inside hsync pulse
        logic vs;   // inside vsync lines
        logic fs;   // pixel (0,0)
    } timing_flags_t;

    function automatic int span_total(input int active, input int fp,
                                      input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction

endpackage

// File: rtl/vid_delay_line.sv
// ---------------------------------------------------------------------------
// vid_delay_line
// DEPTH-stage shift register that delays a WIDTH-bit word by DEPTH cycles.
// Used to align timing flags with the pixel source's read latency.
// Ports:
//   clk_i  in  1      clock
//   rst_i  in  1      asynchronous active-high reset (stages <= RST_VAL)
//   d_i    in  WIDTH  input word
//   q_o    out WIDTH  input word delayed by DEPTH cycles (DEPTH >= 1)
// ---------------------------------------------------------------------------
module vid_delay_line #(
    parameter int               WIDTH   = 1,
    parameter int               DEPTH   = 1,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] stage_q [DEPTH];

    // NOTE: every stage is reset, not just the last one: a stale "active"
    // still in flight after reset would unblank the output for a few cycles.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < DEPTH; i++) stage_q[i] <= RST_VAL;
        end else begin
            stage_q[0] <= d_i;
            for (int i = 1; i < DEPTH; i++) stage_q[i] <= stage_q[i-1];
        end
    end

    assign q_o = stage_q[DEPTH-1];

endmodule

// File: rtl/video_timing_gen.sv
// ---------------------------------------------------------------------------
// video_timing_gen
// Raster timing generator with pixel fetch. Counters walk the raster, issue
// fetch requests for active pixels, and the timing flags are delayed by the
// source read latency so returned pixels line up with hsync/vsync/blanking.
// All outputs lag the counter state by RD_LAT+1 cycles (o_x/o_y/o_pix_req
// are the counter-side request and are not delayed).
// Ports:
//   i_pix_clk        in   pixel clock
//   reset_in         in   asynchronous active-high reset
//   i_enable         in   run timing; low forces counters to (0,0)
//   o_pix_req        out  fetch request, active region only
//   o_x / o_y        out  requested column / row (counter registers)
//   i_pix_data       in   {r,g,b}, RD_LAT cycles after o_pix_req
//   i_pix_valid      in   i_pix_data valid
//   i_clr_underflow  in   clears o_underflow (a new miss wins)
//   hsync / vsync    out  sync at H_POL / V_POL when asserted
//   blanking         out  high outside active video
//   o_data_ch0/1/2   out  blue / green / red, zero when blanked or missing
//   o_frame_start    out  one-cycle pulse with output pixel (0,0)
//   o_underflow      out  sticky: active output pixel had no valid data
// ---------------------------------------------------------------------------
module video_timing_gen
    import vid_timing_pkg::*;
#(
    parameter int H_ACTIVE = H_ACTIVE_720P,
    parameter int H_FP     = H_FP_720P,
    parameter int H_SYNC   = H_SYNC_720P,
    parameter int H_BP     = H_BP_720P,
    parameter int V_ACTIVE = V_ACTIVE_720P,
    parameter int V_FP     = V_FP_720P,
    parameter int V_SYNC   = V_SYNC_720P,
    parameter int V_BP     = V_BP_720P,
    parameter bit H_POL    = 1'b1,
    parameter bit V_POL    = 1'b1,
    parameter int RD_LAT   = 2
) (
    input  logic             i_pix_clk,
    input  logic             reset_in,
    input  logic             i_enable,
    output logic             o_pix_req,
    output logic [X_W-1:0]   o_x,
    output logic [Y_W-1:0]   o_y,
    input  logic [PIX_W-1:0] i_pix_data,
    input  logic             i_pix_valid,
    input  logic             i_clr_underflow,
    output logic             hsync,
    output logic             vsync,
    output logic             blanking,
    output logic [CH_W-1:0]  o_data_ch0,
    output logic [CH_W-1:0]  o_data_ch1,
    output logic [CH_W-1:0]  o_data_ch2,
    output logic             o_frame_start,
    output logic             o_underflow
);

    localparam int H_TOTAL = span_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int V_TOTAL = span_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

    localparam logic [X_W-1:0] H_LAST   = X_W'(H_TOTAL - 1);
    localparam logic [X_W-1:0] H_ACT    = X_W'(H_ACTIVE);
    localparam logic [X_W-1:0] HS_START = X_W'(H_ACTIVE + H_FP);
    localparam logic [X_W-1:0] HS_END   = X_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [Y_W-1:0] V_LAST   = Y_W'(V_TOTAL - 1);
    localparam logic [Y_W-1:0] V_ACT    = Y_W'(V_ACTIVE);
    localparam logic [Y_W-1:0] VS_START = Y_W'(V_ACTIVE + V_FP);
    localparam logic [Y_W-1:0] VS_END   = Y_W'(V_ACTIVE + V_FP + V_SYNC);

    logic             run_q;
    logic [X_W-1:0]   h_cnt_q, h_cnt_d;
    logic [Y_W-1:0]   v_cnt_q, v_cnt_d;
    logic             live;
    timing_flags_t    req_flags, dly_flags, out_flags_q;
    logic [PIX_W-1:0] data_q;
    logic             miss_q;
    logic             underflow_q;

    // run_q is i_enable seen at the previous edge: the counters sit at (0,0)
    // for the first enabled cycle, so the first request is pixel (0,0).
    // Gating with the live i_enable stops requests the moment it drops.
    assign live = run_q & i_enable;

    // NOTE: defaults first so every path assigns both counters; without
    // them the hold case would infer latches.
    always_comb begin
        h_cnt_d = h_cnt_q;
        v_cnt_d = v_cnt_q;
        if (!i_enable) begin
            h_cnt_d = '0;
            v_cnt_d = '0;
        end else if (run_q) begin
            if (h_cnt_q == H_LAST) begin
                h_cnt_d = '0;
                v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + 1'b1;
            end else begin
                h_cnt_d = h_cnt_q + 1'b1;
            end
        end
    end

    // NOTE: non-blocking assignments so all registers update from the
    // pre-edge values regardless of statement order.
    always_ff @(posedge i_pix_clk or posedge reset_in) begin
        if (reset_in) begin
            run_q   <= 1'b0;
            h_cnt_q <= '0;
            v_cnt_q <= '0;
        end else begin
            run_q   <= i_enable;
            h_cnt_q <= h_cnt_d;
            v_cnt_q <= v_cnt_d;
        end
    end

    // v_cnt only moves when h_cnt wraps, so vs only changes at h_cnt = 0.
    always_comb begin
        req_flags.act = live && (h_cnt_q < H_ACT) && (v_cnt_q < V_ACT);
        req_flags.hs  = live && (h_cnt_q >= HS_START) && (h_cnt_q < HS_END);
        req_flags.vs  = live && (v_cnt_q >= VS_START) && (v_cnt_q < VS_END);
        req_flags.fs  = live && (h_cnt_q == '0) && (v_cnt_q == '0);
    end

    vid_delay_line #(
        .WIDTH   ($bits(timing_flags_t)),
        .DEPTH   (RD_LAT),
        .RST_VAL ('0)
    ) u_flag_dly (
        .clk_i (i_pix_clk),
        .rst_i (reset_in),
        .d_i   (req_flags),
        .q_o   (dly_flags)
    );

    // Output register: flags and returned pixel are captured together.
    // miss_q marks an output pixel with no data; the sticky flag follows
    // one edge later, and a new miss beats a simultaneous clear.
    always_ff @(posedge i_pix_clk or posedge reset_in) begin
        if (reset_in) begin
            out_flags_q <= '0;
            data_q      <= '0;
            miss_q      <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            out_flags_q <= dly_flags;
            data_q      <= (dly_flags.act && i_pix_valid) ? i_pix_data : '0;
            miss_q      <= dly_flags.act && !i_pix_valid;
            underflow_q <= miss_q || (underflow_q && !i_clr_underflow);
        end
    end

    assign o_pix_req     = req_flags.act;
    assign o_x           = h_cnt_q;
    assign o_y           = v_cnt_q;
    assign hsync         = out_flags_q.hs ? H_POL : ~H_POL;
    assign vsync         = out_flags_q.vs ? V_POL : ~V_POL;
    assign blanking      = ~out_flags_q.act;
    assign o_frame_start = out_flags_q.fs;
    assign o_underflow   = underflow_q;
    assign o_data_ch2    = data_q[RED_LSB   +: CH_W];
    assign o_data_ch1    = data_q[GREEN_LSB +: CH_W];
    assign o_data_ch0    = data_q[BLUE_LSB  +: CH_W];

endmodule

// File: tb/tb_video_timing_gen.sv
// ---------------------------------------------------------------------------
// tb_video_timing_gen
// Small raster (20 x 9 clocks, 12 x 5 active), read latency 2, active-low
// vsync. A position-from-cycle-count model predicts request and output
// timing; the bench acts as the pixel source ({x, y, A5} after RD_LAT).
// ---------------------------------------------------------------------------
module tb_video_timing_gen;

    localparam int HA = 12, HFP = 3, HSW = 2, HBP = 3;
    localparam int VA = 5, VFP = 1, VSW = 2, VBP = 1;
    localparam int LAT = 2;
    localparam bit HPOL = 1'b1, VPOL = 1'b0;
    localparam int HT = HA + HFP + HSW + HBP;
    localparam int VT = VA + VFP + VSW + VBP;
    localparam int FRAME = HT * VT;

    logic        clk = 1'b0;
    logic        reset_in;
    logic        i_enable;
    logic        o_pix_req;
    logic [10:0] o_x;
    logic [9:0]  o_y;
    logic [23:0] i_pix_data;
    logic        i_pix_valid;
    logic        i_clr_underflow;
    logic        hsync, vsync, blanking;
    logic [7:0]  o_data_ch0, o_data_ch1, o_data_ch2;
    logic        o_frame_start;
    logic        o_underflow;

    video_timing_gen #(
        .H_ACTIVE (HA), .H_FP (HFP), .H_SYNC (HSW), .H_BP (HBP),
        .V_ACTIVE (VA), .V_FP (VFP), .V_SYNC (VSW), .V_BP (VBP),
        .H_POL (HPOL), .V_POL (VPOL), .RD_LAT (LAT)
    ) dut (
        .i_pix_clk       (clk),
        .reset_in        (reset_in),
        .i_enable        (i_enable),
        .o_pix_req       (o_pix_req),
        .o_x             (o_x),
        .o_y             (o_y),
        .i_pix_data      (i_pix_data),
        .i_pix_valid     (i_pix_valid),
        .i_clr_underflow (i_clr_underflow),
        .hsync           (hsync),
        .vsync           (vsync),
        .blanking        (blanking),
        .o_data_ch0      (o_data_ch0),
        .o_data_ch1      (o_data_ch1),
        .o_data_ch2      (o_data_ch2),
        .o_frame_start   (o_frame_start),
        .o_underflow     (o_underflow)
    );

    always #5 clk = ~clk;

    typedef struct { bit act; bit hs; bit vs; bit fs; } flags_t;
    typedef struct { bit req; int x; int y; } fetch_t;

    flags_t      hist[$];     // request-side flags, oldest = due at output now
    fetch_t      fetches[$];  // outstanding requests, oldest = answer now
    int          t;           // cycles since frame start while running
    bit          run;         // enable seen at previous edge
    bit          exp_uf;
    logic [23:0] prev_data;
    bit          prev_valid;
    bit          rand_valid;
    int          miss_x, miss_y;
    int          checks, errors;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic int h_now();
        return t % HT;
    endfunction

    function automatic int v_now();
        return (t / HT) % VT;
    endfunction

    task automatic model_reset();
        t = 0; run = 1'b0; exp_uf = 1'b0;
        prev_data = '0; prev_valid = 1'b0;
        hist.delete();
        fetches.delete();
        for (int i = 0; i <= LAT; i++) hist.push_back('{1'b0, 1'b0, 1'b0, 1'b0});
        for (int i = 0; i < LAT; i++) fetches.push_back('{1'b0, 0, 0});
    endtask

    task automatic check_reset_values();
        check("rst_pix_req", 32'(o_pix_req), 32'(0));
        check("rst_x", 32'(o_x), 32'(0));
        check("rst_y", 32'(o_y), 32'(0));
        check("rst_hsync", 32'(hsync), 32'(!HPOL));
        check("rst_vsync", 32'(vsync), 32'(!VPOL));
        check("rst_blanking", 32'(blanking), 32'(1));
        check("rst_rgb", {8'h0, o_data_ch2, o_data_ch1, o_data_ch0}, 32'(0));
        check("rst_frame_start", 32'(o_frame_start), 32'(0));
        check("rst_underflow", 32'(o_underflow), 32'(0));
    endtask

    // One clock cycle: drive inputs, compare against the model, advance it.
    // Entered and left 1 time unit after a rising edge.
    task automatic step(input bit en, input bit clr);
        int          h, v;
        bit          live, req, valid;
        logic [23:0] data;
        fetch_t      resp;
        flags_t      f;
        h    = h_now();
        v    = v_now();
        live = run && en;
        req  = live && h < HA && v < VA;

        resp = fetches.pop_front();
        fetches.push_back('{req, h, v});
        if (resp.req) begin
            data  = {resp.x[7:0], resp.y[7:0], 8'hA5};
            valid = !(resp.x == miss_x && resp.y == miss_y) &&
                    (!rand_valid || $urandom_range(0, 7) != 0);
        end else begin
            data  = 24'($urandom);
            valid = 1'($urandom_range(0, 1));
        end
        i_enable        = en;
        i_clr_underflow = clr;
        i_pix_data      = data;
        i_pix_valid     = valid;
        #1;

        f = hist.pop_front();
        check("x", 32'(o_x), h);
        check("y", 32'(o_y), v);
        check("pix_req", 32'(o_pix_req), 32'(req));
        check("hsync", 32'(hsync), 32'(f.hs ? HPOL : !HPOL));
        check("vsync", 32'(vsync), 32'(f.vs ? VPOL : !VPOL));
        check("blanking", 32'(blanking), 32'(!f.act));
        check("frame_start", 32'(o_frame_start), 32'(f.fs));
        check("rgb", {8'h0, o_data_ch2, o_data_ch1, o_data_ch0},
              {8'h0, (f.act && prev_valid) ? prev_data : 24'h0});
        check("underflow", 32'(o_underflow), 32'(exp_uf));

        hist.push_back('{req,
                         live && h >= HA + HFP && h < HA + HFP + HSW,
                         live && v >= VA + VFP && v < VA + VFP + VSW,
                         live && h == 0 && v == 0});
        exp_uf     = (f.act && !prev_valid) || (exp_uf && !clr);
        prev_data  = data;
        prev_valid = valid;
        if (!en)     t = 0;
        else if (run) t = (t + 1) % FRAME;
        run = en;
        @(posedge clk);
        #1;
    endtask

    // Reset asserted between edges; outputs must settle without a clock.
    task automatic apply_reset();
        #3;
        reset_in = 1'b1;
        #1;
        check_reset_values();
        @(posedge clk);
        @(posedge clk);
        #1;
        check_reset_values();
        reset_in = 1'b0;
        model_reset();
    endtask

    initial begin
        reset_in = 1'b0; i_enable = 1'b0; i_pix_data = '0;
        i_pix_valid = 1'b0; i_clr_underflow = 1'b0;
        checks = 0; errors = 0;
        rand_valid = 1'b0; miss_x = -1; miss_y = -1;
        model_reset();

        #1 reset_in = 1'b1;
        #1 check_reset_values();
        @(posedge clk);
        @(posedge clk);
        #1 reset_in = 1'b0;
        model_reset();

        // Idle with enable low
        repeat (5) step(1'b0, 1'b0);

        // Pixel (5,0) missing every frame; clear held high makes set and
        // clear coincide (set wins for one cycle), then sticky, then cleared.
        miss_x = 5; miss_y = 0;
        repeat (FRAME) step(1'b1, 1'b1);
        repeat (FRAME) step(1'b1, 1'b0);
        step(1'b1, 1'b1);
        repeat (20) step(1'b1, 1'b0);

        // Random valid and random clear
        miss_x = -1; miss_y = -1; rand_valid = 1'b1;
        repeat (2 * FRAME) step(1'b1, 1'($urandom_range(0, 7) == 0));

        // Enable drop mid-line for 10 cycles, then a full frame from restart
        for (int n = 0; n < FRAME && !(h_now() == HA / 2 && v_now() == 1); n++)
            step(1'b1, 1'b0);
        repeat (10) step(1'b0, 1'b0);
        repeat (FRAME + LAT + 4) step(1'b1, 1'($urandom_range(0, 7) == 0));

        // Asynchronous reset mid-frame, then restart from (0,0)
        for (int n = 0; n < FRAME && !(h_now() == HA - 2 && v_now() == 3); n++)
            step(1'b1, 1'b0);
        apply_reset();
        repeat (FRAME + LAT + 4) step(1'b1, 1'($urandom_range(0, 7) == 0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
